// File: rtl/pipeline_alu_pkg.sv
// Shared opcode encoding and flag bit positions for the pipelined ALU.
package pipeline_alu_pkg;

    typedef enum logic [3:0] {
        FUNC_ADD   = 4'd0,
        FUNC_SUB   = 4'd1,
        FUNC_MUL   = 4'd2,
        FUNC_PASSA = 4'd3,
        FUNC_PASSB = 4'd4,
        FUNC_AND   = 4'd5,
        FUNC_OR    = 4'd6,
        FUNC_XOR   = 4'd7,
        FUNC_NEGA  = 4'd8,
        FUNC_NEGB  = 4'd9,
        FUNC_SRA   = 4'd10,
        FUNC_SLA   = 4'd11
    } func_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/pipeline_alu_p_if.sv
// Instruction issue / write-back bus of pipeline_alu_p.
// Optional flags signal present when ALU_FLAGS_EN is defined.
interface pipeline_alu_p_if #(
    parameter int DW  = 16,
    parameter int RAW = 4,
    parameter int MAW = 8
);
    logic           in_valid;
    logic [RAW-1:0] rs1;
    logic [RAW-1:0] rs2;
    logic [RAW-1:0] rd;
    logic [3:0]     func;
    logic [MAW-1:0] addr;
    logic [DW-1:0]  Z;
    logic           z_valid;
`ifdef ALU_FLAGS_EN
    logic [3:0]     flags;
`endif

    modport master (
        output in_valid, rs1, rs2, rd, func, addr,
        input  Z, z_valid
`ifdef ALU_FLAGS_EN
        , input flags
`endif
    );

    modport slave (
        input  in_valid, rs1, rs2, rd, func, addr,
        output Z, z_valid
`ifdef ALU_FLAGS_EN
        , output flags
`endif
    );
endinterface

// File: rtl/pipeline_alu_p_alu_core.sv
// Combinational ALU: result and (with ALU_FLAGS_EN) raw {N,Z,C,V} flags.
module alu_core
    import pipeline_alu_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [3:0]    func,
    output logic [DW-1:0] r
`ifdef ALU_FLAGS_EN
    , output logic [3:0]  flags
`endif
);

    always_comb begin
        r = '0;
        case (func)
            FUNC_ADD:   r = a + b;
            FUNC_SUB:   r = a - b;
            FUNC_MUL:   r = a * b;
            FUNC_PASSA: r = a;
            FUNC_PASSB: r = b;
            FUNC_AND:   r = a & b;
            FUNC_OR:    r = a | b;
            FUNC_XOR:   r = a ^ b;
            FUNC_NEGA:  r = '0 - a;
            FUNC_NEGB:  r = '0 - b;
            FUNC_SRA:   r = {a[DW-1], a[DW-1:1]};
            FUNC_SLA:   r = {a[DW-2:0], 1'b0};
            default:    r = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    // Carry detected by unsigned wrap of the sum; borrow when a < b.
    always_comb begin
        flags         = '0;
        flags[FLAG_N] = r[DW-1];
        flags[FLAG_Z] = (r == '0);
        if (func == FUNC_ADD) begin
            flags[FLAG_C] = (r < a);
            flags[FLAG_V] = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
        end else if (func == FUNC_SUB) begin
            flags[FLAG_C] = (a < b);
            flags[FLAG_V] = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
        end
    end
`endif

endmodule

// File: rtl/pipeline_alu_p.sv
// Three-stage fetch / execute / write-back ALU with full RAW forwarding.
// Define ALU_FLAGS_EN to add the registered {N,Z,C,V} flags output.
module pipeline_alu_p
    import pipeline_alu_pkg::*;
#(
    parameter int DW        = 16,
    parameter int NREG      = 16,
    parameter int MEM_DEPTH = 256
) (
    input  logic          clk1,
    input  logic          rst_n,
    pipeline_alu_p_if.slave bus
);

    localparam int RAW = $clog2(NREG);
    localparam int MAW = $clog2(MEM_DEPTH);

    logic [DW-1:0]  regbank [NREG];
    logic [DW-1:0]  mem     [MEM_DEPTH];

    logic           v1;
    logic [DW-1:0]  a1, b1;
    logic [RAW-1:0] rd1;
    logic [3:0]     func1;
    logic [MAW-1:0] addr1;

    logic           v2;
    logic [DW-1:0]  r2;
    logic [RAW-1:0] rd2;
    logic [MAW-1:0] addr2;

    logic [DW-1:0]  alu_r;
    logic [DW-1:0]  opa, opb;

`ifdef ALU_FLAGS_EN
    logic [3:0]     alu_flags;
    logic [3:0]     flags2;
`endif

    alu_core #(.DW(DW)) u_alu (
        .a    (a1),
        .b    (b1),
        .func (func1),
        .r    (alu_r)
`ifdef ALU_FLAGS_EN
        , .flags(alu_flags)
`endif
    );

    // Newest producer wins; the stage-2 path also covers the same-edge regbank write.
    assign opa = (v1 && rd1 == bus.rs1) ? alu_r :
                 (v2 && rd2 == bus.rs1) ? r2    : regbank[bus.rs1];
    assign opb = (v1 && rd1 == bus.rs2) ? alu_r :
                 (v2 && rd2 == bus.rs2) ? r2    : regbank[bus.rs2];

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            a1      <= '0;
            b1      <= '0;
            rd1     <= '0;
            func1   <= '0;
            addr1   <= '0;
            v2      <= 1'b0;
            r2      <= '0;
            rd2     <= '0;
            addr2   <= '0;
            bus.Z       <= '0;
            bus.z_valid <= 1'b0;
`ifdef ALU_FLAGS_EN
            flags2    <= '0;
            bus.flags <= '0;
`endif
        end else begin
            v1    <= bus.in_valid;
            a1    <= opa;
            b1    <= opb;
            rd1   <= bus.rd;
            func1 <= bus.func;
            addr1 <= bus.addr;

            v2    <= v1;
            r2    <= alu_r;
            rd2   <= rd1;
            addr2 <= addr1;
`ifdef ALU_FLAGS_EN
            flags2 <= alu_flags;
`endif

            bus.z_valid <= v2;
            if (v2) begin
                bus.Z <= r2;
`ifdef ALU_FLAGS_EN
                bus.flags <= flags2;
`endif
            end
        end
    end

    // Storage is not reset; v2 is held low during reset so nothing is written.
    always_ff @(posedge clk1) begin
        if (v2) begin
            regbank[rd2] <= r2;
            mem[addr2]   <= r2;
        end
    end

endmodule
